// File: rtl/rx_ctrl_pkg.sv
// rx_ctrl_pkg
//   Shared types and defaults for the OFDM receive acquisition controller.
//   - acq_state_e : acquisition state encoding, visible on ostate
//   - rx_cfg_t    : M/SS/BW configuration bundle
//   - *_DEF       : default timing parameters for a 1024+32 symbol, 50-symbol frame
//   - cnt_width() : width of the frame-period counter
package rx_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RESET_DP = 3'd0,
      ST_SEARCH   = 3'd1,
      ST_VERIFY   = 3'd2,
      ST_LOCKED   = 3'd3
   } acq_state_e;

   typedef struct packed {
      logic [2:0] m;
      logic [3:0] ss;
      logic [2:0] bw;
   } rx_cfg_t;

   localparam int unsigned SYM_LEN_DEF   = 1056;
   localparam int unsigned FRAME_SYM_DEF = 50;
   localparam int unsigned TOL_DEF       = 4;
   localparam int unsigned LOCK_CNT_DEF  = 3;
   localparam int unsigned MISS_MAX_DEF  = 2;
   localparam int unsigned RST_HOLD_DEF  = 16;

   // The counter must reach P+tol and one saturation value beyond it.
   function automatic int unsigned cnt_width(input int unsigned period, input int unsigned tol);
      return $clog2(period + tol + 2);
   endfunction

endpackage

// File: rtl/rx_acq_timer.sv
// rx_acq_timer
//   Frame-period counter. Counts cycles since the last accepted sop and
//   flags where the current cycle sits relative to the expected period.
//   Ports:
//     clk, rst       : clock, asynchronous active-low reset
//     iclr           : force count to 0 (highest priority)
//     iload_one      : accepted sop, count restarts at 1
//     iload_fly      : flywheel after a missed sop, count restarts at tol+1
//     oin_win        : P-tol <= cnt <= P+tol
//     oearly         : cnt <  P-tol
//     otimeout       : cnt == P+tol (caller decides whether a sop overrides it)
module rx_acq_timer #(
   parameter int unsigned pPERIOD = 52800,
   parameter int unsigned pTOL    = 4,
   parameter int unsigned pCNT_W  = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic iclr,
   input  logic iload_one,
   input  logic iload_fly,
   output logic oin_win,
   output logic oearly,
   output logic otimeout
);

   localparam logic [pCNT_W-1:0] WIN_LO  = pCNT_W'(pPERIOD - pTOL);
   localparam logic [pCNT_W-1:0] WIN_HI  = pCNT_W'(pPERIOD + pTOL);
   localparam logic [pCNT_W-1:0] CNT_SAT = pCNT_W'(pPERIOD + pTOL + 1);
   // Reloading tol+1 at the timeout cycle (cnt = P+tol) makes the next
   // expected sop land exactly one period after the one that was missed.
   localparam logic [pCNT_W-1:0] FLY_VAL = pCNT_W'(pTOL + 1);

   logic [pCNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (iclr) begin
         cnt_d = '0;
      end else if (iload_one) begin
         cnt_d = pCNT_W'(1);
      end else if (iload_fly) begin
         cnt_d = FLY_VAL;
      end else if (cnt_q != CNT_SAT) begin
         cnt_d = cnt_q + pCNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign oearly   = (cnt_q < WIN_LO);
   assign oin_win  = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
   assign otimeout = (cnt_q == WIN_HI);

endmodule

// File: rtl/rx_acq_ctrl.sv
// rx_acq_ctrl
//   Frame acquisition and sequencing controller for the OFDM receive chain.
//   Qualifies correlator sops against the frame period, declares lock/loss,
//   drives the datapath soft reset and applies config on frame boundaries.
//   Ports:
//     clk, rst                      : clock, asynchronous active-low reset
//     ienable                       : 0 drops to RESET_DP and holds off acquisition
//     isop_corr                     : raw correlator start-of-preamble pulse
//     idemap_sof                    : demapper start-of-frame (config boundary)
//     iindex_M/SS/BW                : requested configuration
//     ocfg_M/SS/BW, ocfg_upd        : active configuration, change pulse
//     odp_rst_n                     : datapath soft reset, active-low
//     ofrsync_sop                   : qualified sop to frame sync
//     olock, olost                  : locked level, lock-loss pulse
//     ostate                        : current state encoding
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   RESET_DP  | datapath held in reset for the hold time, then wait enable
//   SEARCH    | waiting for any correlator sop
//   VERIFY    | counting consecutive in-window sops towards lock
//   LOCKED    | forwarding in-window sops, flywheeling over missed ones
module rx_acq_ctrl
   import rx_ctrl_pkg::*;
#(
   parameter int unsigned pSYM_LEN   = SYM_LEN_DEF,
   parameter int unsigned pFRAME_SYM = FRAME_SYM_DEF,
   parameter int unsigned pTOL       = TOL_DEF,
   parameter int unsigned pLOCK_CNT  = LOCK_CNT_DEF,
   parameter int unsigned pMISS_MAX  = MISS_MAX_DEF,
   parameter int unsigned pRST_HOLD  = RST_HOLD_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ienable,
   input  logic       isop_corr,
   input  logic       idemap_sof,
   input  logic [2:0] iindex_M,
   input  logic [3:0] iindex_SS,
   input  logic [2:0] iindex_BW,
   output logic [2:0] ocfg_M,
   output logic [3:0] ocfg_SS,
   output logic [2:0] ocfg_BW,
   output logic       ocfg_upd,
   output logic       odp_rst_n,
   output logic       ofrsync_sop,
   output logic       olock,
   output logic       olost,
   output logic [2:0] ostate
);

   localparam int unsigned PERIOD  = pSYM_LEN * pFRAME_SYM;
   localparam int unsigned CNT_W   = cnt_width(PERIOD, pTOL);
   localparam int unsigned MATCH_W = $clog2(pLOCK_CNT + 1);
   localparam int unsigned MISS_W  = $clog2(pMISS_MAX + 1);
   localparam int unsigned HOLD_W  = $clog2(pRST_HOLD + 1);

   localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(pLOCK_CNT);
   localparam logic [MISS_W-1:0]  MISS_LOST  = MISS_W'(pMISS_MAX);
   // Hold counts down to zero; the exit edge is the one that sees zero, so
   // odp_rst_n stays low for exactly pRST_HOLD cycles.
   localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(pRST_HOLD - 1);

   acq_state_e         state_q, state_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   rx_cfg_t            cfg_q, cfg_d;
   logic               cfg_upd_q, cfg_upd_d;
   logic               dp_rst_n_q, dp_rst_n_d;
   logic               frsync_sop_q, frsync_sop_d;
   logic               lock_q, lock_d;
   logic               lost_q, lost_d;

   logic               enter_rst;
   logic               tmr_clr, tmr_load_one, tmr_load_fly;
   logic               in_win, early, timeout;
   logic [MATCH_W-1:0] match_inc;
   logic [MISS_W-1:0]  miss_inc;

   rx_acq_timer #(
      .pPERIOD (PERIOD),
      .pTOL    (pTOL),
      .pCNT_W  (CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .iclr      (tmr_clr),
      .iload_one (tmr_load_one),
      .iload_fly (tmr_load_fly),
      .oin_win   (in_win),
      .oearly    (early),
      .otimeout  (timeout)
   );

   assign match_inc = match_q + MATCH_W'(1);
   assign miss_inc  = miss_q + MISS_W'(1);

   always_comb begin
      state_d      = state_q;
      match_d      = match_q;
      miss_d       = miss_q;
      hold_d       = hold_q;
      dp_rst_n_d   = 1'b1;
      frsync_sop_d = 1'b0;
      lost_d       = 1'b0;
      tmr_clr      = 1'b0;
      tmr_load_one = 1'b0;
      tmr_load_fly = 1'b0;
      enter_rst    = 1'b0;

      if (!ienable && (state_q != ST_RESET_DP)) begin
         enter_rst = 1'b1;
      end else begin
         case (state_q)
            ST_RESET_DP: begin
               tmr_clr = 1'b1;
               match_d = '0;
               miss_d  = '0;
               if (hold_q != '0) begin
                  hold_d     = hold_q - HOLD_W'(1);
                  dp_rst_n_d = 1'b0;
               end else if (ienable) begin
                  state_d = ST_SEARCH;
               end
            end

            ST_SEARCH: begin
               if (isop_corr) begin
                  state_d      = ST_VERIFY;
                  match_d      = MATCH_W'(1);
                  tmr_load_one = 1'b1;
               end
            end

            ST_VERIFY: begin
               if (isop_corr) begin
                  tmr_load_one = 1'b1;
                  if (in_win && !early) begin
                     match_d = match_inc;
                     if (match_inc == MATCH_LOCK) begin
                        state_d      = ST_LOCKED;
                        miss_d       = '0;
                        frsync_sop_d = 1'b1;
                     end
                  end else begin
                     match_d = MATCH_W'(1);
                  end
               end else if (timeout) begin
                  state_d = ST_SEARCH;
                  match_d = '0;
               end
            end

            ST_LOCKED: begin
               // Out-of-window sops fall through and are ignored; a sop
               // on the timeout cycle is in-window and wins.
               if (isop_corr && in_win) begin
                  frsync_sop_d = 1'b1;
                  miss_d       = '0;
                  tmr_load_one = 1'b1;
               end else if (timeout) begin
                  if (miss_inc == MISS_LOST) begin
                     lost_d    = 1'b1;
                     enter_rst = 1'b1;
                  end else begin
                     miss_d       = miss_inc;
                     tmr_load_fly = 1'b1;
                  end
               end
            end

            default: enter_rst = 1'b1;
         endcase
      end

      if (enter_rst) begin
         state_d    = ST_RESET_DP;
         hold_d     = HOLD_INIT;
         dp_rst_n_d = 1'b0;
         tmr_clr    = 1'b1;
         match_d    = '0;
         miss_d     = '0;
      end

      lock_d = (state_d == ST_LOCKED);
   end

   // Config follows the request until lock, then only moves on frame starts
   // so the chain never sees a mid-frame change.
   always_comb begin
      cfg_d = cfg_q;
      if ((state_q != ST_LOCKED) || idemap_sof) begin
         cfg_d = {iindex_M, iindex_SS, iindex_BW};
      end
      cfg_upd_d = (cfg_d != cfg_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_RESET_DP;
         match_q      <= '0;
         miss_q       <= '0;
         hold_q       <= HOLD_INIT;
         cfg_q        <= '0;
         cfg_upd_q    <= 1'b0;
         dp_rst_n_q   <= 1'b0;
         frsync_sop_q <= 1'b0;
         lock_q       <= 1'b0;
         lost_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         match_q      <= match_d;
         miss_q       <= miss_d;
         hold_q       <= hold_d;
         cfg_q        <= cfg_d;
         cfg_upd_q    <= cfg_upd_d;
         dp_rst_n_q   <= dp_rst_n_d;
         frsync_sop_q <= frsync_sop_d;
         lock_q       <= lock_d;
         lost_q       <= lost_d;
      end
   end

   assign ocfg_M      = cfg_q.m;
   assign ocfg_SS     = cfg_q.ss;
   assign ocfg_BW     = cfg_q.bw;
   assign ocfg_upd    = cfg_upd_q;
   assign odp_rst_n   = dp_rst_n_q;
   assign ofrsync_sop = frsync_sop_q;
   assign olock       = lock_q;
   assign olost       = lost_q;
   assign ostate      = state_q;

endmodule

// File: doc/rx_acq_ctrl.md
# rx_acq_ctrl

Frame-acquisition and sequencing controller for the OFDM receive chain. Sits between the correlator/sync-filter outputs and the frame-sync, CP-removal and demapper stages. It qualifies raw correlator start-of-preamble pulses against the expected frame period, declares lock and loss of lock, and generates the datapath soft reset. It also applies M/SS/BW configuration changes only on frame boundaries.

## Interface
- pSYM_LEN, 1056 — cycles per OFDM symbol (1024 + CP 32)
- pFRAME_SYM, 50 — symbols per frame; frame period P = pSYM_LEN*pFRAME_SYM
- pTOL, 4 — accepted sop jitter, ± cycles around P
- pLOCK_CNT, 3 — consecutive in-window sops needed to lock
- pMISS_MAX, 2 — consecutive missed sops that drop lock
- pRST_HOLD, 16 — cycles odp_rst_n is held low
- clk  in  1  datapath clock (clk_low_data domain)
- rst  in  1  asynchronous, active-low reset
- ienable  in  1  0 forces RESET_DP→SEARCH hold (no acquisition)
- isop_corr  in  1  raw correlator sop pulse
- idemap_sof  in  1  demapper start-of-frame pulse
- iindex_M / iindex_SS / iindex_BW  in  3/4/3  requested config
- ocfg_M / ocfg_SS / ocfg_BW  out  3/4/3  active config to RX chain
- ocfg_upd  out  1  one-cycle pulse when active config changes
- odp_rst_n  out  1  datapath soft reset, active-low
- ofrsync_sop  out  1  qualified sop to fr_sync
- olock  out  1  high in LOCKED
- olost  out  1  one-cycle pulse on lock loss
- ostate  out  3  current state encoding

## Operation
- States: RESET_DP(0), SEARCH(1), VERIFY(2), LOCKED(3).
- Counter cnt: width clog2(P+pTOL+2); accepted sop loads cnt←1; otherwise cnt←cnt+1 (saturating). In-window ⇔ P−pTOL ≤ cnt ≤ P+pTOL. Timeout ⇔ cnt = P+pTOL with no sop in that cycle.
- RESET_DP: odp_rst_n=0, hold counter runs pRST_HOLD cycles → SEARCH (only if ienable=1; else stay with odp_rst_n released after hold).
- SEARCH: isop_corr → VERIFY, match←1, cnt←1.
- VERIFY: in-window sop → match+1, cnt←1; match+1 = pLOCK_CNT → LOCKED. Early sop (cnt < P−pTOL) → restart: match←1, cnt←1. Timeout → SEARCH.
- LOCKED: in-window sop → ofrsync_sop, miss←0, cnt←1. Out-of-window sop ignored. Timeout → miss+1, flywheel cnt←pTOL+1; miss+1 = pMISS_MAX → olost pulse, RESET_DP.
- The locking sop (VERIFY→LOCKED) also produces ofrsync_sop.
- Config: in RESET_DP/SEARCH/VERIFY, ocfg_* track iindex_* each cycle. In LOCKED, ocfg_* update only on idemap_sof. ocfg_upd pulses when any ocfg_* changes value.
- ienable falling in any state → RESET_DP.
- isop_corr coincident with timeout counts as sop (sop wins).

## Timing
- Reset values: state RESET_DP, odp_rst_n=0, ocfg_*=0, ocfg_upd=0, ofrsync_sop=0, olock=0, olost=0, cnt=0, match=0, miss=0.
- After rst deasserts: odp_rst_n rises after exactly pRST_HOLD clocks.
- ofrsync_sop, olock, olost, ocfg_*: registered, 1-cycle latency from the causing input.
- Reset mid-operation: all state cleared asynchronously; no pulse outputs are emitted on release.

## Structure
- Package rx_ctrl_pkg holds the state enum typedef, the state encodings, and the default timing localparams.
- Sub-module rx_acq_timer holds cnt, the window and timeout compares, and the flywheel reload. It outputs in_win, early and timeout flags.
- Top level holds the FSM, the match/miss/hold counters and the config shadow registers.

## Test plan
Bench parameters: pSYM_LEN=20, pFRAME_SYM=5 (P=100), pTOL=4, pLOCK_CNT=3, pMISS_MAX=2, pRST_HOLD=16.
- Reset: hold rst low 10 cycles, then release. Required: odp_rst_n=0 for 16 cycles then 1, and ostate=1.
- Acquisition: sops at t=0,100,200,300. Required: olock=1 and ofrsync_sop at t=201; ofrsync_sop again at t=301.
- Jitter: sop intervals of 104 and 96 are accepted. In VERIFY, an interval of 105 gives timeout at cnt=104 → SEARCH; the sop at 105 then re-enters VERIFY with match=1.
- Loss: lock, then stop sops. Required: first miss at 104 cycles after the last sop; olost pulse and ostate=0 at 204 cycles after it; odp_rst_n low 16 cycles.
- Spurious sop while locked at cnt=50. Required: no ofrsync_sop, olock stays 1, the next sop at cnt=100 is accepted.
- Config change while locked: iindex_M 2→4 at an arbitrary time. Required: ocfg_M stays 2 until the cycle after the next idemap_sof, then 4 with one ocfg_upd pulse.
